// File: rtl/nf_ahb_dec_dp.sv
// nf_ahb_dec_dp: AHB-lite address decoder and data-phase response mux.
// Decodes the address phase into a one-hot slave select, registers the
// selection for the data phase, and routes the chosen slave's read data,
// response and ready back to the master. Transfers that hit no slave are
// answered by an internal default slave with a two-cycle ERROR response,
// and each such access is logged (saturating count plus last address).
//
// Default slave states:
//   state    | meaning
//   ST_IDLE  | no unmapped transfer in its data phase
//   ST_ERR1  | first ERROR cycle, hready low, hresp ERROR
//   ST_ERR2  | second ERROR cycle, hready high, hresp ERROR

`ifndef SLAVE_COUNT
`define SLAVE_COUNT 2
`endif

module nf_ahb_dec_dp #(
    parameter int                       slave_c   = `SLAVE_COUNT,
    parameter logic [slave_c-1:0][31:0] addr_base = '0,
    parameter logic [slave_c-1:0][31:0] addr_mask = '0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [31:0]             haddr,
    input  logic [1:0]              htrans,
    output logic [slave_c-1:0]      hsel,
    input  logic [slave_c*32-1:0]   hrdata_s,
    input  logic [slave_c*2-1:0]    hresp_s,
    input  logic [slave_c-1:0]      hready_s,
    output logic [31:0]             hrdata,
    output logic [1:0]              hresp,
    output logic                    hready,
    output logic [15:0]             err_cnt,
    output logic [31:0]             err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nx;
    logic               xfer;
    logic [slave_c-1:0] match;
    logic               found;
    logic               to_dflt;
    logic [slave_c-1:0] sel_q;
    logic               err_load;
    logic [15:0]        err_cnt_q;
    logic [31:0]        err_addr_q;

    // Only NONSEQ and SEQ carry a real transfer.
    assign xfer = (htrans == 2'b10) || (htrans == 2'b11);

    // Masked base-address compare for every slave.
    always_comb begin
        match = '0;
        for (int i = 0; i < slave_c; i++) begin
            match[i] = ((haddr & addr_mask[i]) == (addr_base[i] & addr_mask[i]));
        end
    end

    // Lowest matching index wins; a valid transfer with no match goes to the default slave.
    always_comb begin
        hsel    = '0;
        found   = 1'b0;
        to_dflt = 1'b0;
        if (xfer) begin
            for (int i = 0; i < slave_c; i++) begin
                if (match[i] && !found) begin
                    hsel[i] = 1'b1;
                    found   = 1'b1;
                end
            end
            to_dflt = !found;
        end
    end

    // Data-phase select advances only when the current data phase completes.
    // An all-zero select means either "none" or the default slave (FSM owns that case).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q <= '0;
        end else if (hready) begin
            sel_q <= hsel;
        end
    end

    // Default slave state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Data-phase response mux: default slave error cycles override the slave path.
    always_comb begin
        hrdata = '0;
        hresp  = 2'b00;
        hready = 1'b1;
        case (state_q)
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 2'b01;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 2'b01;
            end
            default: begin
                for (int i = 0; i < slave_c; i++) begin
                    if (sel_q[i]) begin
                        hrdata = hrdata_s[32*i +: 32];
                        hresp  = hresp_s[2*i +: 2];
                        hready = hready_s[i];
                    end
                end
            end
        endcase
    end

    // Default slave next state; a new unmapped address phase is accepted only with hready high.
    always_comb begin
        state_nx = state_q;
        err_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hready && to_dflt) begin
                    state_nx = ST_ERR1;
                    err_load = 1'b1;
                end
            end
            ST_ERR1: begin
                state_nx = ST_ERR2;
            end
            ST_ERR2: begin
                if (hready && to_dflt) begin
                    state_nx = ST_ERR1;
                    err_load = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Unmapped-access log: latest address and a count that sticks at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (err_load) begin
            err_addr_q <= haddr;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule
